// File: rtl/branch_resolution_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolution_unit
// Brief    : In-order in-flight prediction queue; trains the branch history
//            table on resolve and pulses mispredict/flush on a wrong guess.
//            Optional BRU_STATS_EN adds saturating branch/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolution_unit #(
  parameter int LOWER = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pred_valid,
  input  logic [LOWER-1:0] pred_addr,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic             res_jump,
  output logic             upd_en,
  output logic [LOWER-1:0] upd_addr,
  output logic             upd_taken,
  output logic             mispredict,
  output logic             flush,
  output logic             empty,
  output logic             full,
`ifdef BRU_STATS_EN
  output logic [15:0]      branch_cnt,
  output logic [15:0]      miss_cnt,
`endif
  output logic             err
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {
    S_RUN     = 1'b0,
    S_RECOVER = 1'b1
  } state_t;

  state_t               state_q;
  logic [LOWER-1:0]     addr_mem_q  [DEPTH];
  logic                 taken_mem_q [DEPTH];
  logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0]   count_q, count_d;
  logic                 upd_en_q, upd_taken_q, miss_q, err_q;
  logic [LOWER-1:0]     upd_addr_q;

  logic w_run, w_empty, w_full, w_push, w_pop, w_outcome, w_miss, w_err_set;

  assign w_run     = (state_q == S_RUN);
  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == c_CNT_W'(DEPTH));
  assign w_push    = en & pred_valid & pred_ready;
  assign w_pop     = en & res_valid & ~w_empty & w_run;
  assign w_outcome = res_taken | res_jump;
  assign w_miss    = w_pop & (w_outcome != taken_mem_q[rd_ptr_q]);
  assign w_err_set = en & ((pred_valid & ~pred_ready) | (res_valid & w_empty & w_run));

  assign pred_ready = ~w_full & w_run;
  assign empty      = w_empty;
  assign full       = w_full;
  assign err        = err_q;
  assign upd_addr   = upd_addr_q;
  assign upd_taken  = upd_taken_q;
  // Pulses are held while stalled and only presented on an enabled cycle
  assign upd_en     = upd_en_q & en;
  assign mispredict = miss_q & en;
  assign flush      = miss_q & en;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_miss) begin
      // Wrong path: everything younger than the head is discarded, incl. this cycle's push
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + c_CNT_W'(1);
        2'b01:   count_d = count_q - c_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      upd_en_q    <= 1'b0;
      upd_addr_q  <= '0;
      upd_taken_q <= 1'b0;
      miss_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (w_err_set) err_q <= 1'b1;
      if (en) begin
        upd_en_q <= w_pop;
        miss_q   <= w_miss;
        if (w_pop) begin
          upd_addr_q  <= addr_mem_q[rd_ptr_q];
          upd_taken_q <= w_outcome;
        end
        case (state_q)
          S_RUN:     if (w_miss) state_q <= S_RECOVER;
          S_RECOVER: state_q <= S_RUN;
          default:   state_q <= S_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      addr_mem_q[wr_ptr_q]  <= pred_addr;
      taken_mem_q[wr_ptr_q] <= pred_taken;
    end
  end

`ifdef BRU_STATS_EN
  logic [15:0] branch_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (w_pop && (branch_cnt_q != 16'hFFFF)) branch_cnt_q <= branch_cnt_q + 16'd1;
      if (w_miss && (miss_cnt_q != 16'hFFFF))  miss_cnt_q   <= miss_cnt_q + 16'd1;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;
`endif

endmodule
`default_nettype wire
